// File: rtl/lfsr_pkg.sv
// Shared types, tap constants and feedback helper for the parametrised PRBS generator/checker.
package lfsr_pkg;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      SYNC = 2'd1,
      LOCK = 2'd2
   } chk_state_t;

   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;
   localparam logic [3:0]  TAPS_4  = 4'hC;

   // Feedback bit is the parity of the tapped state bits; callers zero-extend to 32 bits.
   function automatic logic lfsr_fb(input logic [31:0] state, input logic [31:0] taps);
      return ^(state & taps);
   endfunction

endpackage

// File: rtl/lfsr_err_cnt.sv
// Saturating mismatch counter; a same-cycle clear and increment leaves the count at one.
module lfsr_err_cnt #(
   parameter int ERR_W = 8
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             clr,
   input  logic             inc,
   output logic [ERR_W-1:0] count
);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         count <= '0;
      end else if (clr) begin
         count <= inc ? ERR_W'(1) : '0;
      end else if (inc && (count != '1)) begin
         count <= count + ERR_W'(1);
      end
   end

endmodule

// File: rtl/lfsr_gen_chk.sv
// Parametrised PRBS generator / self-synchronising checker with lock detection.
// Define LFSR_CHECKER_EN to build the checker; without it the block is generator only.
//
// state | meaning
// HUNT  | shifting DIN into the state until WIDTH bits are loaded
// SYNC  | still loading DIN, counting consecutive feedback matches
// LOCK  | free-running on feedback, mismatches counted as errors
module lfsr_gen_chk
   import lfsr_pkg::*;
#(
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] TAPS   = WIDTH'(TAPS_8),
   parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
   parameter int               SYNC_N = 4,
   parameter int               LOSS_N = 3,
   parameter int               ERR_W  = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             LFSR_EN,
   input  logic             MODE,
   input  logic             DIN,
   input  logic             CLR_ERR,
   output logic             LFSR_BIT,
   output logic             LFSR_PERIOD,
   output logic [WIDTH-1:0] LFSR_STATE,
   output logic             LOCKED,
   output logic             ERR_PULSE,
   output logic [ERR_W-1:0] ERR_COUNT
);

   logic [WIDTH-1:0] state_q, state_d;
   logic             period_q, period_d;
   logic             fb, zero_st, nxt, gen_mode, err_inc, cnt_clr;

   assign fb      = lfsr_fb(32'(state_q), 32'(TAPS));
   assign zero_st = (state_q == '0);

`ifdef LFSR_CHECKER_EN
   localparam int LD_W = $clog2(WIDTH + 1);
   localparam int MT_W = $clog2(SYNC_N + 1);
   localparam int MS_W = $clog2(LOSS_N + 1);
   localparam logic [LD_W-1:0] LOAD_LAST = LD_W'(WIDTH - 1);
   localparam logic [MT_W-1:0] SYNC_LAST = MT_W'(SYNC_N - 1);
   localparam logic [MS_W-1:0] LOSS_LAST = MS_W'(LOSS_N - 1);

   chk_state_t      chk_q, chk_d;
   logic [LD_W-1:0] ld_q, ld_d;
   logic [MT_W-1:0] mt_q, mt_d;
   logic [MS_W-1:0] ms_q, ms_d;
   logic            locked_q, locked_d, err_q, err_d, match;

   assign gen_mode = !MODE;
   assign match    = (DIN == fb);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         chk_q    <= HUNT;
         ld_q     <= '0;
         mt_q     <= '0;
         ms_q     <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         chk_q    <= chk_d;
         ld_q     <= ld_d;
         mt_q     <= mt_d;
         ms_q     <= ms_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   // An all-zero state is being reseeded, so it neither loads nor compares.
   always_comb begin
      chk_d = chk_q;
      ld_d  = ld_q;
      mt_d  = mt_q;
      ms_d  = ms_q;
      if (LFSR_EN) begin
         if (!MODE) begin
            chk_d = HUNT;
            ld_d  = '0;
            mt_d  = '0;
            ms_d  = '0;
         end else if (!zero_st) begin
            case (chk_q)
               HUNT: begin
                  if (ld_q == LOAD_LAST) begin
                     chk_d = SYNC;
                     ld_d  = '0;
                     mt_d  = '0;
                  end else begin
                     ld_d = ld_q + LD_W'(1);
                  end
               end
               SYNC: begin
                  if (!match) begin
                     chk_d = HUNT;
                     ld_d  = '0;
                     mt_d  = '0;
                  end else if (mt_q == SYNC_LAST) begin
                     chk_d = LOCK;
                     mt_d  = '0;
                     ms_d  = '0;
                  end else begin
                     mt_d = mt_q + MT_W'(1);
                  end
               end
               LOCK: begin
                  if (match) begin
                     ms_d = '0;
                  end else if (ms_q == LOSS_LAST) begin
                     chk_d = HUNT;
                     ld_d  = '0;
                     ms_d  = '0;
                  end else begin
                     ms_d = ms_q + MS_W'(1);
                  end
               end
               default: chk_d = HUNT;
            endcase
         end
      end
   end

   always_comb begin
      nxt      = (MODE && (chk_q != LOCK)) ? DIN : fb;
      locked_d = (chk_d == LOCK);
      err_d    = LFSR_EN && MODE && !zero_st && (chk_q == LOCK) && !match;
   end

   assign err_inc   = err_d;
   assign cnt_clr   = CLR_ERR;
   assign LOCKED    = locked_q;
   assign ERR_PULSE = err_q;
`else
   logic [1:0] unused_in;

   assign unused_in = {^{MODE, DIN, CLR_ERR}, ((SYNC_N + LOSS_N) > 0)};
   assign gen_mode  = 1'b1;
   assign nxt       = fb;
   assign err_inc   = 1'b0;
   assign cnt_clr   = 1'b0;
   assign LOCKED    = 1'b0;
   assign ERR_PULSE = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      if (LFSR_EN) begin
         state_d = zero_st ? SEED : {state_q[WIDTH-2:0], nxt};
      end
      period_d = LFSR_EN && gen_mode && (state_d == SEED);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= SEED;
         period_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
      end
   end

   // With the checker compiled out both controls are tied low and the count stays at zero.
   lfsr_err_cnt #(.ERR_W(ERR_W)) u_err_cnt (
      .clk_sys (CLK),
      .rst_b   (RESET),
      .clr     (cnt_clr),
      .inc     (err_inc),
      .count   (ERR_COUNT)
   );

   assign LFSR_STATE  = state_q;
   assign LFSR_BIT    = state_q[0];
   assign LFSR_PERIOD = period_q;

endmodule

// File: tb/tb_lfsr_gen_chk.sv
// Self-checking bench for lfsr_gen_chk; checker scenarios run when LFSR_CHECKER_EN is defined.
module tb_lfsr_gen_chk;
   import lfsr_pkg::*;

   localparam logic [7:0] SEED = 8'h01;

   logic       CLK = 1'b0;
   logic       RESET, LFSR_EN, MODE, DIN, CLR_ERR;
   logic       LFSR_BIT, LFSR_PERIOD, LOCKED, ERR_PULSE;
   logic [7:0] LFSR_STATE, ERR_COUNT;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         exp_err  = 0;
   logic [7:0] gen_s;

   lfsr_gen_chk dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .LFSR_EN     (LFSR_EN),
      .MODE        (MODE),
      .DIN         (DIN),
      .CLR_ERR     (CLR_ERR),
      .LFSR_BIT    (LFSR_BIT),
      .LFSR_PERIOD (LFSR_PERIOD),
      .LFSR_STATE  (LFSR_STATE),
      .LOCKED      (LOCKED),
      .ERR_PULSE   (ERR_PULSE),
      .ERR_COUNT   (ERR_COUNT)
   );

   always #5 CLK = ~CLK;

   // Reference: state doubles, new LSB is the parity of the tapped bits; zero reseeds.
   function automatic logic [7:0] prbs_next(input logic [7:0] s);
      int v;
      if (s == 8'h00) return SEED;
      v = int'(s) * 2 + ($countones(s & TAPS_8) % 2);
      return 8'(v % 256);
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Drive the next reference stream bit (optionally inverted) and clock it in.
   task automatic feed(input logic flip);
      logic [7:0] n;
      n     = prbs_next(gen_s);
      DIN   = n[0] ^ flip;
      gen_s = n;
      tick();
   endtask

   task automatic apply_reset();
      RESET   = 1'b0;
      LFSR_EN = 1'b0;
      MODE    = 1'b0;
      DIN     = 1'b0;
      CLR_ERR = 1'b0;
      tick();
      tick();
      RESET = 1'b1;
   endtask

   task automatic test_reset();
      RESET   = 1'b0;
      LFSR_EN = 1'b1;
      MODE    = 1'b0;
      DIN     = 1'b1;
      CLR_ERR = 1'b0;
      tick();
      tick();
      n_checks++;
      if (LFSR_STATE !== SEED) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected %h", LFSR_STATE, SEED);
      end
      n_checks++;
      if (LFSR_BIT !== SEED[0]) begin
         n_fail++;
         $display("FAIL reset_bit: got %b expected %b", LFSR_BIT, SEED[0]);
      end
      n_checks++;
      if ({LFSR_PERIOD, LOCKED, ERR_PULSE} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 000", {LFSR_PERIOD, LOCKED, ERR_PULSE});
      end
      n_checks++;
      if (ERR_COUNT !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_errcnt: got %0d expected 0", ERR_COUNT);
      end
      LFSR_EN = 1'b0;
      tick();
      RESET = 1'b1;
   endtask

   task automatic test_gen_sequence();
      logic [7:0] exp_s [0:6];
      logic       exp_b [0:6];
      exp_s = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
      exp_b = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      MODE    = 1'b0;
      LFSR_EN = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         n_checks++;
         if (LFSR_STATE !== exp_s[i]) begin
            n_fail++;
            $display("FAIL gen_seq step %0d: got %h expected %h", i, LFSR_STATE, exp_s[i]);
         end
         n_checks++;
         if (LFSR_BIT !== exp_b[i]) begin
            n_fail++;
            $display("FAIL gen_bit step %0d: got %b expected %b", i, LFSR_BIT, exp_b[i]);
         end
      end
   endtask

   // Random enable gaps; the model tracks state and the return-to-seed pulse.
   task automatic test_period();
      logic [7:0] s;
      logic       en, exp_p;
      int         en_cnt, pulses;
      apply_reset();
      s      = SEED;
      en_cnt = 0;
      pulses = 0;
      for (int c = 0; c < 700; c++) begin
         en      = ($urandom_range(0, 3) != 0);
         LFSR_EN = en;
         exp_p   = 1'b0;
         if (en) begin
            s = prbs_next(s);
            en_cnt++;
            exp_p = (s == SEED);
         end
         tick();
         n_checks++;
         if (LFSR_STATE !== s) begin
            n_fail++;
            $display("FAIL period_state cycle %0d: got %h expected %h", c, LFSR_STATE, s);
         end
         n_checks++;
         if (LFSR_PERIOD !== exp_p) begin
            n_fail++;
            $display("FAIL period_pulse cycle %0d: got %b expected %b", c, LFSR_PERIOD, exp_p);
         end
         if (LFSR_PERIOD === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses != en_cnt / 255) begin
         n_fail++;
         $display("FAIL period_count: got %0d pulses expected %0d", pulses, en_cnt / 255);
      end
      LFSR_EN = 1'b0;
   endtask

`ifdef LFSR_CHECKER_EN
   task automatic expect_relock(input string tag);
      for (int i = 1; i <= 12; i++) begin
         feed(1'b0);
         n_checks++;
         if (LOCKED !== (i == 12)) begin
            n_fail++;
            $display("FAIL %s cycle %0d: LOCKED=%b expected %b", tag, i, LOCKED, (i == 12));
         end
      end
   endtask

   task automatic test_lock();
      apply_reset();
      MODE    = 1'b1;
      LFSR_EN = 1'b1;
      gen_s   = 8'($urandom_range(1, 255));
      exp_err = 0;
      expect_relock("lock_rise");
      for (int i = 0; i < 1000; i++) begin
         feed(1'b0);
         n_checks++;
         if ({LOCKED, ERR_PULSE} !== 2'b10) begin
            n_fail++;
            $display("FAIL lock_clean cycle %0d: LOCKED,ERR_PULSE=%b expected 10", i, {LOCKED, ERR_PULSE});
         end
      end
      n_checks++;
      if (ERR_COUNT !== 8'h00) begin
         n_fail++;
         $display("FAIL lock_errcnt: got %0d expected 0", ERR_COUNT);
      end
   endtask

   task automatic test_single_error();
      feed(1'b1);
      exp_err = 1;
      n_checks++;
      if ({LOCKED, ERR_PULSE} !== 2'b11) begin
         n_fail++;
         $display("FAIL single_err_flags: got %b expected 11", {LOCKED, ERR_PULSE});
      end
      n_checks++;
      if (ERR_COUNT !== 8'(exp_err)) begin
         n_fail++;
         $display("FAIL single_err_count: got %0d expected %0d", ERR_COUNT, exp_err);
      end
      feed(1'b0);
      n_checks++;
      if ({LOCKED, ERR_PULSE} !== 2'b10) begin
         n_fail++;
         $display("FAIL single_err_after: got %b expected 10", {LOCKED, ERR_PULSE});
      end
   endtask

   task automatic test_loss_relock();
      for (int k = 1; k <= 3; k++) begin
         feed(1'b1);
         exp_err++;
         n_checks++;
         if ({LOCKED, ERR_PULSE} !== {(k < 3), 1'b1}) begin
            n_fail++;
            $display("FAIL loss_flags err %0d: got %b expected %b", k, {LOCKED, ERR_PULSE}, {(k < 3), 1'b1});
         end
      end
      n_checks++;
      if (ERR_COUNT !== 8'(exp_err)) begin
         n_fail++;
         $display("FAIL loss_count: got %0d expected %0d", ERR_COUNT, exp_err);
      end
      expect_relock("relock");
   endtask

   task automatic test_saturation();
      for (int e = 0; e < 300; e++) begin
         feed(1'b1);
         exp_err = (exp_err < 255) ? exp_err + 1 : 255;
         n_checks++;
         if (ERR_COUNT !== 8'(exp_err) || LOCKED !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_count err %0d: got %0d/%b expected %0d/1", e, ERR_COUNT, LOCKED, exp_err);
         end
         repeat ($urandom_range(1, 2)) feed(1'b0);
      end
      CLR_ERR = 1'b1;
      feed(1'b1);
      CLR_ERR = 1'b0;
      exp_err = 1;
      n_checks++;
      if (ERR_COUNT !== 8'(exp_err)) begin
         n_fail++;
         $display("FAIL clr_plus_err: got %0d expected %0d", ERR_COUNT, exp_err);
      end
      feed(1'b0);
   endtask

   task automatic test_enable_hold();
      LFSR_EN = 1'b0;
      for (int i = 0; i < 5; i++) begin
         DIN = 1'($urandom);
         tick();
         n_checks++;
         if (LFSR_STATE !== gen_s || {LOCKED, ERR_PULSE, LFSR_PERIOD} !== 3'b100 ||
             ERR_COUNT !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL en_hold cycle %0d: state %h flags %b cnt %0d expected %h 100 %0d",
                     i, LFSR_STATE, {LOCKED, ERR_PULSE, LFSR_PERIOD}, ERR_COUNT, gen_s, exp_err);
         end
      end
      LFSR_EN = 1'b1;
      for (int i = 0; i < 20; i++) begin
         feed(1'b0);
         n_checks++;
         if ({LOCKED, ERR_PULSE} !== 2'b10) begin
            n_fail++;
            $display("FAIL en_resume cycle %0d: got %b expected 10", i, {LOCKED, ERR_PULSE});
         end
      end
   endtask

   task automatic test_mode_switch();
      MODE = 1'b0;
      for (int i = 0; i < 5; i++) begin
         gen_s = prbs_next(gen_s);
         tick();
         n_checks++;
         if (LFSR_STATE !== gen_s || LOCKED !== 1'b0 || ERR_COUNT !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL mode_gen cycle %0d: state %h lock %b cnt %0d expected %h 0 %0d",
                     i, LFSR_STATE, LOCKED, ERR_COUNT, gen_s, exp_err);
         end
      end
      LFSR_EN = 1'b0;
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      LFSR_EN = 1'b1;
      exp_err = 0;
      n_checks++;
      if (ERR_COUNT !== 8'h00) begin
         n_fail++;
         $display("FAIL clr_no_en: got %0d expected 0", ERR_COUNT);
      end
      MODE = 1'b1;
      expect_relock("mode_relock");
   endtask

   task automatic test_reset_mid();
      feed(1'b1);
      RESET = 1'b0;
      #2;
      n_checks++;
      if (LFSR_STATE !== SEED || LOCKED !== 1'b0 || ERR_COUNT !== 8'h00 || ERR_PULSE !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: state %h lock %b cnt %0d pulse %b expected %h 0 0 0",
                  LFSR_STATE, LOCKED, ERR_COUNT, ERR_PULSE, SEED);
      end
      tick();
      RESET = 1'b1;
      feed(1'b0);
      n_checks++;
      if (LOCKED !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_hunt: LOCKED=%b expected 0", LOCKED);
      end
   endtask
`else
   task automatic test_gen_only();
      logic [7:0] s;
      apply_reset();
      MODE    = 1'b1;
      LFSR_EN = 1'b1;
      s       = SEED;
      for (int i = 0; i < 60; i++) begin
         DIN     = 1'($urandom);
         CLR_ERR = 1'($urandom);
         s       = prbs_next(s);
         tick();
         n_checks++;
         if (LFSR_STATE !== s || {LOCKED, ERR_PULSE} !== 2'b00 || ERR_COUNT !== 8'h00) begin
            n_fail++;
            $display("FAIL gen_only cycle %0d: state %h flags %b cnt %0d expected %h 00 0",
                     i, LFSR_STATE, {LOCKED, ERR_PULSE}, ERR_COUNT, s);
         end
      end
   endtask
`endif

   initial begin
      RESET   = 1'b0;
      LFSR_EN = 1'b0;
      MODE    = 1'b0;
      DIN     = 1'b0;
      CLR_ERR = 1'b0;
      gen_s   = SEED;
      test_reset();
      test_gen_sequence();
      test_period();
`ifdef LFSR_CHECKER_EN
      test_lock();
      test_single_error();
      test_loss_relock();
      test_saturation();
      test_enable_hold();
      test_mode_switch();
      test_reset_mid();
`else
      test_gen_only();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lfsr_gen_chk.md
Name: lfsr_gen_chk

Overview:
- Parametrised successor to the fixed 8-bit LFSR. It has configurable width, taps and seed.
- Runs either as a PRBS generator or as a self-synchronising PRBS checker with lock detection and a saturating error counter.
- Sits on the CLK_OUT domain next to the SISO chain. The generator feeds SISO_in; a second instance in check mode verifies the SISO D_OUT stream.

Parameters:
- WIDTH, 8, LFSR length in bits (3..32).
- TAPS, 8'hB8, feedback mask. Bit k set means state[k] is XORed into the feedback.
- SEED, 8'h01, nonzero reset/recovery state, WIDTH bits.
- SYNC_N, 4, consecutive matches required in SYNC before LOCK.
- LOSS_N, 3, consecutive mismatches in LOCK that force a return to HUNT.
- ERR_W, 8, error counter width.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous reset, active-low.
- LFSR_EN  in  1  advance enable. State and FSM freeze when low.
- MODE  in  1  0 = generate, 1 = check.
- DIN  in  1  serial stream under check, sampled on enabled cycles.
- CLR_ERR  in  1  synchronous clear of ERR_COUNT.
- LFSR_BIT  out  1  newest state bit, equal to state[0].
- LFSR_PERIOD  out  1  one-cycle pulse in generate mode when the updated state equals SEED.
- LFSR_STATE  out  WIDTH  current state register.
- LOCKED  out  1  high while the checker FSM is in LOCK.
- ERR_PULSE  out  1  one-cycle pulse on each mismatch while in LOCK.
- ERR_COUNT  out  ERR_W  saturating mismatch count.

Behaviour:
- All outputs are registered.
- Reset values: state = SEED, LFSR_BIT = SEED[0], LFSR_PERIOD = 0, FSM = HUNT, LOCKED = 0, ERR_PULSE = 0, ERR_COUNT = 0.
- Feedback: fb = XOR of (state & TAPS). Update on an enabled cycle is state <= {state[WIDTH-2:0], nxt}.
- Generate mode: nxt = fb. The FSM is held in HUNT, match/miss counters are cleared, and LOCKED = 0.
- Generate-mode latency: the first enabled cycle after reset yields the state after one shift.
- Period is 2^WIDTH-1 for a primitive TAPS; 255 for the defaults.
- All-zero recovery: if state is all-zero on an enabled cycle, the next state is SEED and no compare is made.
- Check mode, per enabled cycle: match = (DIN == fb).
- HUNT: nxt = DIN. After WIDTH loaded bits, go to SYNC with the match counter at 0.
- SYNC: nxt = DIN. A match increments the counter; after SYNC_N matches go to LOCK. A mismatch goes to HUNT and restarts the load count.
- LOCK: nxt = fb, so the checker free-runs and is immune to single errors.
  - Each mismatch raises ERR_PULSE and increments ERR_COUNT, saturating at all-ones.
  - LOSS_N consecutive mismatches go to HUNT and drop LOCKED. A match clears the miss counter.
- CLR_ERR: same-cycle CLR_ERR and a mismatch give ERR_COUNT = 1 (the clear wins, then the increment). CLR_ERR works regardless of LFSR_EN.
- MODE change: MODE 0->1 enters HUNT next cycle with the state register kept. MODE 1->0 switches to generation from the current state. ERR_COUNT is kept across both.
- LFSR_EN low: no state, FSM or counter change. ERR_PULSE and LFSR_PERIOD are 0.
- Reset asserted mid-operation returns every register to its reset value immediately.

Optional Feature:
- Macro: LFSR_CHECKER_EN.
- Defined: full checker (FSM, counters, LOCKED, ERR_PULSE, ERR_COUNT) as above.
- Undefined: generator only. MODE, DIN and CLR_ERR are ignored and listed as unused. LOCKED, ERR_PULSE and ERR_COUNT are tied to 0. This saves area on the tile.

Decomposition:
- Package lfsr_pkg holds:
  - chk_state_t enum {HUNT, SYNC, LOCK}.
  - Tap constants TAPS_8 = 8'hB8, TAPS_16 = 16'hB400, TAPS_4 = 4'hC.
  - A pure function lfsr_fb(state, taps).
- One sub-module, lfsr_err_cnt: ERR_W saturating counter with clear, increment and clear-plus-increment priority.

Test Plan:
- Defaults, reset released, LFSR_EN = 1, MODE = 0: LFSR_STATE = 02, 04, 08, 11, 23, 47, 8E. LFSR_BIT = 0, 0, 0, 1, 1, 1, 0. LFSR_PERIOD pulses every 255 enabled cycles.
- Generator instance feeding a checker instance (MODE = 1) started at an arbitrary offset: LOCKED rises exactly 8 + 4 = 12 enabled cycles after check start. ERR_COUNT stays 0 over 1000 cycles.
- While locked, flip one DIN bit: a single ERR_PULSE, ERR_COUNT = 1, LOCKED stays 1.
- While locked, flip 3 consecutive DIN bits: LOCKED drops after the third. The checker relocks 12 cycles after a clean stream resumes.
- Force 300 errors with ERR_W = 8: ERR_COUNT saturates at 255. CLR_ERR plus a mismatch in the same cycle gives 1.
- Assert RESET mid-LOCK, and toggle LFSR_EN low for 5 cycles: reset restores SEED, HUNT, ERR_COUNT = 0. LFSR_EN low causes no state change and no pulses.
